tx_permit_ctrl: RTL and testbench
=================================

TX_PERMIT_CTRL -- requirements
Module: tx_permit_ctrl

Interface
REQ-001 clk  input  1  system clock; the block uses this single clock only.
REQ-002 reset_n  input  1  reset, asynchronous, active-low.
REQ-003 period_ls  input  16  low-speed bit period minus one, in clk cycles.
REQ-004 idle_wait_len  input  8  idle bits required before the bus counts as idle.
REQ-005 tx_wait_len  input  10  extra priority-slot bits after idle, used when arbitrate=1.
REQ-006 arbitrate  input  1  1: enforce the priority slot; 0: permit as soon as the bus is idle.
REQ-007 tx_pending  input  1  TX frame waiting (pp_ram unread).
REQ-008 tx_active  input  1  serializer driving the bus (tx_en from the TX byte serializer).
REQ-009 cd  input  1  collision-detect pulse from the serializer.
REQ-010 rx  input  1  bus line, already synchronized to clk.
REQ-011 cd_cnt_clr  input  1  pulse; clears cd_cnt.
REQ-012 tx_permit  output  1  level grant to the serializer.
REQ-013 bus_idle  output  1  bus idle for at least idle_wait_len bits.
REQ-014 cd_cnt  output  8  saturating collision count.

Function
REQ-015 The bit timer shall be a 16-bit counter, cleared while rx=0 or tx_active=1.
REQ-016 Otherwise the bit timer shall increment, and when it equals period_ls it shall emit a one-cycle bit_tick and wrap to 0, giving period_ls+1 clocks per bit.
REQ-017 idle_bits shall be an 11-bit counter, cleared while rx=0, tx_active=1 or cd=1.
REQ-018 idle_bits shall increment on each bit_tick and saturate at 2047 with no wrap.
REQ-019 The permit threshold shall be computed in 11 bits: idle_wait_len + (arbitrate ? tx_wait_len : 0), with no overflow possible.
REQ-020 The FSM shall have five states: BUSY, IDLE_CNT, WAIT_SLOT, PERMIT, TX.
REQ-021 BUSY -> IDLE_CNT on the first cycle with rx=1 and tx_active=0.
REQ-022 IDLE_CNT -> WAIT_SLOT when idle_bits >= idle_wait_len.
REQ-023 WAIT_SLOT -> PERMIT when idle_bits >= threshold and tx_pending=1.
REQ-024 WAIT_SLOT shall remain in WAIT_SLOT while tx_pending=0, and the bus shall stay idle.
REQ-025 PERMIT -> TX when tx_active=1.
REQ-026 PERMIT -> WAIT_SLOT when tx_pending falls.
REQ-027 TX -> BUSY when tx_active falls or cd=1.
REQ-028 Any state -> BUSY on rx=0 while tx_active=0; this rule takes priority over all other transitions except reset.
REQ-029 cd=1 in any state shall force BUSY, so the full idle wait plus slot repeats before any retry.
REQ-030 bus_idle shall be registered and equal 1 exactly when the state is WAIT_SLOT, PERMIT or TX.
REQ-031 bus_idle and tx_permit shall follow the state with one cycle of latency.
REQ-032 tx_permit shall be registered and equal 1 exactly when the state is PERMIT and tx_pending=1.
REQ-033 On rx falling, tx_permit shall drop on the next cycle.
REQ-034 If rx falls on the same cycle the threshold is reached, rx=0 shall win and no permit shall be issued.
REQ-035 cd_cnt shall increment on each cd pulse and saturate at 255.
REQ-036 cd_cnt_clr shall set cd_cnt to 0; when cd_cnt_clr and cd coincide, cd_cnt shall become 1.
REQ-037 Changing any configuration input mid-wait shall take effect on the next comparison, with no glitch beyond one cycle.

Reset
REQ-038 While reset_n=0: state BUSY, bit timer 0, idle_bits 0, tx_permit 0, bus_idle 0, cd_cnt 0.
REQ-039 After release, the bus shall never be treated as idle until idle_wait_len bits of rx=1 have been counted.
REQ-040 Reset asserted mid-PERMIT or mid-TX shall drop tx_permit and bus_idle asynchronously.

Structure
REQ-041 FSM state encodings (one-hot, 5 bits) and the idle_bits width (11) shall be placed in the shared cdbus package.
REQ-042 The bit timer shall be a sub-module bit_timer (inputs: clr, period; output: tick), reusable by the RX side.
REQ-043 All other logic shall be flat within tx_permit_ctrl.

Verification
REQ-044 period_ls=3, idle_wait_len=10, arbitrate=1, tx_wait_len=2, tx_pending=1, rx=1 from reset -> bus_idle rises on cycle 41 and tx_permit on cycle 49 after the first idle cycle.
REQ-045 Same setup, rx low for 1 cycle at idle bit 11 -> bus_idle and tx_permit both low the next cycle; tx_permit re-asserts 48 cycles after rx returns high.
REQ-046 tx_permit high, tx_active rises, then cd pulses -> BUSY, cd_cnt=1, no permit until idle_bits counts 12 bits again.
REQ-047 arbitrate=0, other settings as REQ-044 -> tx_permit rises on cycle 41, the same cycle as bus_idle.
REQ-048 idle_wait_len=255, tx_wait_len=1023, period_ls=0 -> tx_permit at bit 1278; idle_bits holds at 2047 with no wrap.
REQ-049 Reset asserted in PERMIT; separately, 300 cd pulses then cd_cnt_clr together with cd -> reset drops outputs immediately; cd_cnt reads 255, then 1.

Source files
------------

// File: rtl/cdbus_pkg.sv
// Shared definitions for the collision-detect bus blocks.
//   IDLE_BITS_W / IDLE_BITS_MAX : width and ceiling of the idle-bit counter
//   tx_state_e                  : one-hot TX permit FSM encoding
//   permit_threshold()          : idle bits needed before a permit may be issued
package cdbus_pkg;

    localparam int IDLE_BITS_W = 11;
    localparam logic [IDLE_BITS_W-1:0] IDLE_BITS_MAX = '1;

    typedef enum logic [4:0] {
        ST_BUSY      = 5'b00001,
        ST_IDLE_CNT  = 5'b00010,
        ST_WAIT_SLOT = 5'b00100,
        ST_PERMIT    = 5'b01000,
        ST_TX        = 5'b10000
    } tx_state_e;

    // 255 + 1023 fits in 11 bits, so the sum can never overflow.
    function automatic logic [IDLE_BITS_W-1:0] permit_threshold(
        input logic [7:0] idle_wait_len,
        input logic [9:0] tx_wait_len,
        input logic       arbitrate
    );
        logic [IDLE_BITS_W-1:0] slot;
        slot = arbitrate ? {1'b0, tx_wait_len} : '0;
        return {3'b000, idle_wait_len} + slot;
    endfunction

endpackage

// File: rtl/tx_permit_ctrl_if.sv
// Handshake between the TX byte serializer and the permit controller.
//   tx_pending : frame waiting to be sent
//   tx_active  : serializer is driving the bus
//   cd         : collision-detect pulse
//   tx_permit  : level grant back to the serializer
//   master = serializer side, slave = permit controller side
interface tx_permit_ctrl_if;
    logic tx_pending;
    logic tx_active;
    logic cd;
    logic tx_permit;

    modport master (output tx_pending, output tx_active, output cd, input tx_permit);
    modport slave  (input tx_pending, input tx_active, input cd, output tx_permit);
endinterface

// File: rtl/bit_timer.sv
// Bit-period timer: emits a one-cycle tick every period+1 clocks while clr is low.
//   clk, reset_n : clock, async active-low reset
//   clr          : hold the counter at zero
//   period       : bit period minus one, in clk cycles
//   tick         : one-cycle pulse at the end of each bit
module bit_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic [W-1:0] period,
    output logic         tick
);
    logic [W-1:0] cnt;

    // >= rather than == so that lowering period mid-bit ends the bit on the
    // next cycle instead of running the counter all the way round.
    assign tick = !clr && (cnt >= period);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/tx_permit_ctrl.sv
// TX permit controller: watches the bus line, counts idle bits and grants the
// serializer a transmit slot once the bus has been idle long enough.
//   clk, reset_n                       : clock, async active-low reset
//   period_ls                          : low-speed bit period minus one
//   idle_wait_len, tx_wait_len, arbitrate : idle / priority-slot configuration
//   rx                                 : synchronized bus line
//   cd_cnt_clr                         : clears the collision counter
//   txif (slave)                       : tx_pending/tx_active/cd in, tx_permit out
//   bus_idle                           : bus idle for at least idle_wait_len bits
//   cd_cnt                             : saturating collision count
//
// state     | meaning
// BUSY      | bus driven or collision seen; waiting for rx=1 with no local TX
// IDLE_CNT  | bus released, counting idle bits up to idle_wait_len
// WAIT_SLOT | bus idle, counting priority-slot bits or waiting for a frame
// PERMIT    | serializer allowed to start
// TX        | serializer transmitting
module tx_permit_ctrl
    import cdbus_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic [15:0]   period_ls,
    input  logic [7:0]    idle_wait_len,
    input  logic [9:0]    tx_wait_len,
    input  logic          arbitrate,
    input  logic          rx,
    input  logic          cd_cnt_clr,
    tx_permit_ctrl_if.slave txif,
    output logic          bus_idle,
    output logic [7:0]    cd_cnt
);
    logic                   bit_tick;
    logic                   timer_clr;
    logic                   idle_clr;
    logic                   idle_reached;
    logic                   slot_reached;
    logic                   bus_taken;
    logic [IDLE_BITS_W-1:0] idle_bits;
    logic [IDLE_BITS_W-1:0] threshold;
    tx_state_e              state;
    tx_state_e              state_nxt;
    logic                   bus_idle_nxt;
    logic                   permit_nxt;

    assign timer_clr = !rx || txif.tx_active;
    assign idle_clr  = timer_clr || txif.cd;

    bit_timer #(.W(16)) u_bit_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (timer_clr),
        .period (period_ls),
        .tick   (bit_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_bits <= '0;
        end else if (idle_clr) begin
            idle_bits <= '0;
        end else if (bit_tick && (idle_bits != IDLE_BITS_MAX)) begin
            idle_bits <= idle_bits + 1'b1;
        end
    end

    assign threshold    = permit_threshold(idle_wait_len, tx_wait_len, arbitrate);
    assign idle_reached = idle_bits >= {3'b000, idle_wait_len};
    assign slot_reached = (idle_bits >= threshold) && txif.tx_pending;
    // Someone else on the bus, or a collision: restart the whole idle wait.
    assign bus_taken    = (!rx && !txif.tx_active) || txif.cd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_BUSY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus_taken) begin
            state_nxt = ST_BUSY;
        end else begin
            case (state)
                ST_BUSY: begin
                    if (!txif.tx_active) state_nxt = ST_IDLE_CNT;
                end
                ST_IDLE_CNT: begin
                    // Fall straight through to PERMIT when no slot is needed.
                    if (idle_reached) state_nxt = slot_reached ? ST_PERMIT : ST_WAIT_SLOT;
                end
                ST_WAIT_SLOT: begin
                    if (slot_reached) state_nxt = ST_PERMIT;
                end
                ST_PERMIT: begin
                    if (txif.tx_active)        state_nxt = ST_TX;
                    else if (!txif.tx_pending) state_nxt = ST_WAIT_SLOT;
                end
                ST_TX: begin
                    if (!txif.tx_active) state_nxt = ST_BUSY;
                end
                default: state_nxt = ST_BUSY;
            endcase
        end
        bus_idle_nxt = state_nxt inside {ST_WAIT_SLOT, ST_PERMIT, ST_TX};
        permit_nxt   = (state_nxt == ST_PERMIT) && txif.tx_pending;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_idle       <= 1'b0;
            txif.tx_permit <= 1'b0;
        end else begin
            bus_idle       <= bus_idle_nxt;
            txif.tx_permit <= permit_nxt;
        end
    end

    // A clear coinciding with a collision keeps that collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cd_cnt <= '0;
        end else if (cd_cnt_clr) begin
            cd_cnt <= txif.cd ? 8'd1 : 8'd0;
        end else if (txif.cd && (cd_cnt != 8'hff)) begin
            cd_cnt <= cd_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_tx_permit_ctrl.sv
module tb_tx_permit_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] period_ls;
    logic [7:0]  idle_wait_len;
    logic [9:0]  tx_wait_len;
    logic        arbitrate;
    logic        rx;
    logic        cd_cnt_clr;
    logic        bus_idle;
    logic [7:0]  cd_cnt;

    tx_permit_ctrl_if txif ();

    tx_permit_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .period_ls    (period_ls),
        .idle_wait_len(idle_wait_len),
        .tx_wait_len  (tx_wait_len),
        .arbitrate    (arbitrate),
        .rx           (rx),
        .cd_cnt_clr   (cd_cnt_clr),
        .txif         (txif),
        .bus_idle     (bus_idle),
        .cd_cnt       (cd_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       bi;
        logic       tp;
        logic [7:0] cc;
        int         at;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected output levels as last pushed to the scoreboard.
    logic       m_bi = 1'b0;
    logic       m_tp = 1'b0;
    logic [7:0] m_cc = 8'd0;

    task automatic push(input logic bi, input logic tp, input logic [7:0] cc,
                        input int at, input string name);
        exp_t e;
        e.bi = bi; e.tp = tp; e.cc = cc; e.at = at; e.name = name;
        sb.push_back(e);
        m_bi = bi; m_tp = tp; m_cc = cc;
    endtask

    // Inputs are driven 2 time units after a rising edge; cyc is then the
    // number of that edge, and the next edge samples the new inputs.
    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic apply_reset(input string name);
        reset_n = 1'b0;
        if (m_bi || m_tp || (m_cc != 8'd0)) push(1'b0, 1'b0, 8'd0, cyc, name);
        wait_to(cyc + 3);
        reset_n = 1'b1;
    endtask

    // Monitor: every visible change of the outputs must match the next
    // scoreboard entry, both in value and in the cycle it appears.
    logic [9:0] prev = '0;
    exp_t       cur;
    always @(negedge clk) begin
        if ({bus_idle, txif.tx_permit, cd_cnt} !== prev) begin
            prev = {bus_idle, txif.tx_permit, cd_cnt};
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change cyc=%0d got bi=%0b tp=%0b cd_cnt=%0d, required no change",
                         cyc, bus_idle, txif.tx_permit, cd_cnt);
            end else begin
                cur = sb.pop_front();
                if ({bus_idle, txif.tx_permit, cd_cnt} !== {cur.bi, cur.tp, cur.cc} || cyc != cur.at) begin
                    n_fail++;
                    $display("FAIL %s got bi=%0b tp=%0b cd_cnt=%0d at cyc %0d, required bi=%0b tp=%0b cd_cnt=%0d at cyc %0d",
                             cur.name, bus_idle, txif.tx_permit, cd_cnt, cyc,
                             cur.bi, cur.tp, cur.cc, cur.at);
                end
            end
        end
    end

    task automatic check_direct(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    int b;

    initial begin
        reset_n         = 1'b1;
        period_ls       = 16'd3;
        idle_wait_len   = 8'd10;
        tx_wait_len     = 10'd2;
        arbitrate       = 1'b1;
        rx              = 1'b1;
        cd_cnt_clr      = 1'b0;
        txif.tx_pending = 1'b1;
        txif.tx_active  = 1'b0;
        txif.cd         = 1'b0;
        #1 reset_n = 1'b0;
        @(posedge clk);
        #2;
        wait_to(3);
        check_direct("reset_bus_idle", int'(bus_idle), 0);
        check_direct("reset_tx_permit", int'(txif.tx_permit), 0);
        check_direct("reset_cd_cnt", int'(cd_cnt), 0);
        reset_n = 1'b1;

        // Idle wait 10 bits of 4 clocks, then a 2-bit priority slot.
        b = cyc;
        push(1, 0, 0, b + 41, "a_bus_idle");
        push(1, 1, 0, b + 49, "a_permit");
        wait_to(b + 60);

        // One-cycle rx glitch at idle bit 11, then rx drop while permitted.
        apply_reset("b_reset");
        b = cyc;
        push(1, 0, 0, b + 41, "b_bus_idle");
        wait_to(b + 44);
        rx = 1'b0;
        push(0, 0, 0, b + 45, "b_glitch_drop");
        wait_to(b + 45);
        rx = 1'b1;
        push(1, 0, 0, b + 86, "b_bus_idle_again");
        push(1, 1, 0, b + 94, "b_permit_again");
        wait_to(b + 96);
        rx = 1'b0;
        push(0, 0, 0, b + 97, "b_permit_drop");
        wait_to(b + 97);
        rx = 1'b1;
        push(1, 0, 0, b + 138, "b_bus_idle_third");
        push(1, 1, 0, b + 146, "b_permit_third");
        wait_to(b + 150);

        // rx falls on the cycle the threshold is reached: no permit.
        apply_reset("c_reset");
        b = cyc;
        push(1, 0, 0, b + 41, "c_bus_idle");
        wait_to(b + 48);
        rx = 1'b0;
        push(0, 0, 0, b + 49, "c_tie_rx_wins");
        wait_to(b + 49);
        rx = 1'b1;
        push(1, 0, 0, b + 90, "c_bus_idle_again");
        push(1, 1, 0, b + 98, "c_permit");

        // Transmit start, collision, full wait before retry, pending toggle.
        wait_to(b + 100);
        txif.tx_active = 1'b1;
        push(1, 0, 0, b + 101, "d_tx_start");
        wait_to(b + 103);
        txif.cd = 1'b1;
        push(0, 0, 1, b + 104, "d_cd_busy");
        wait_to(b + 104);
        txif.cd = 1'b0;
        wait_to(b + 106);
        txif.tx_active = 1'b0;
        push(1, 0, 1, b + 147, "d_retry_bus_idle");
        push(1, 1, 1, b + 155, "d_retry_permit");
        wait_to(b + 157);
        txif.tx_pending = 1'b0;
        push(1, 0, 1, b + 158, "d_pending_fall");
        wait_to(b + 160);
        txif.tx_pending = 1'b1;
        push(1, 1, 1, b + 161, "d_pending_rise");
        wait_to(b + 165);

        // No arbitration: permit together with bus_idle.
        arbitrate = 1'b0;
        apply_reset("e_reset");
        b = cyc;
        push(1, 1, 0, b + 41, "e_no_arb_permit");
        wait_to(b + 45);

        // Maximum thresholds, one clock per bit; idle_bits saturates.
        period_ls     = 16'd0;
        idle_wait_len = 8'd255;
        tx_wait_len   = 10'd1023;
        arbitrate     = 1'b1;
        apply_reset("f_reset");
        b = cyc;
        push(1, 0, 0, b + 256, "f_bus_idle");
        push(1, 1, 0, b + 1279, "f_permit");
        wait_to(b + 2100);
        check_direct("f_idle_bits_sat", int'(dut.idle_bits), 2047);

        // Reset in PERMIT must drop outputs without waiting for a clock edge.
        apply_reset("g_async_reset");

        // 300 collision pulses, then clear together with a collision.
        for (int i = 0; i < 300; i++) begin
            txif.cd = 1'b1;
            if (i < 255) push(0, 0, 8'(i + 1), cyc + 1, "g_cd_count");
            wait_to(cyc + 1);
            txif.cd = 1'b0;
            wait_to(cyc + 1);
        end
        cd_cnt_clr = 1'b1;
        txif.cd    = 1'b1;
        push(0, 0, 1, cyc + 1, "g_clr_with_cd");
        wait_to(cyc + 1);
        txif.cd = 1'b0;
        push(0, 0, 0, cyc + 1, "g_clr");
        wait_to(cyc + 1);
        cd_cnt_clr = 1'b0;
        wait_to(cyc + 5);

        check_direct("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
